// File: rtl/dmt_pkg.sv
// Shared definitions for the difference measurement timer front end.
// Contents:
//   state_t          - capture FSM state encoding (ST_IDLE, ST_MEASURE)
//   *_DEF            - default parameter values for the capture block
//   res_width()      - width of one result entry: {sat, count}
//   ptr_width()      - FIFO pointer width (address bits plus one wrap bit)
package dmt_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  localparam int CNT_WIDTH_DEF   = 32;
  localparam int FIFO_DEPTH_DEF  = 8;
  localparam int SYNC_STAGES_DEF = 2;

  // A result entry is {sat, count}: the saturation flag sits in the MSB.
  function automatic int res_width(input int cnt_w);
    return cnt_w + 1;
  endfunction

  // The extra MSB distinguishes full from empty when the address bits match.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dmt_event_capture_if.sv
// Result pop port between the event-capture stage and its consumer.
// Signals:
//   res_data_o  - head-of-FIFO result in cycles (driven by master)
//   res_sat_o   - head entry saturated flag      (driven by master)
//   res_valid_o - FIFO not empty                 (driven by master)
//   res_ready_i - pop request                    (driven by slave)
// Modports: master = capture stage, slave = register slave / consumer.
interface dmt_event_capture_if #(
  parameter int CNT_WIDTH = 32
) ();

  logic [CNT_WIDTH-1:0] res_data_o;
  logic                 res_sat_o;
  logic                 res_valid_o;
  logic                 res_ready_i;

  modport master (
    output res_data_o,
    output res_sat_o,
    output res_valid_o,
    input  res_ready_i
  );

  modport slave (
    input  res_data_o,
    input  res_sat_o,
    input  res_valid_o,
    output res_ready_i
  );

endinterface

// File: rtl/dmt_result_fifo.sv
// Synchronous first-word-fall-through FIFO for measurement results.
// Ports:
//   i_clk, i_rst - clock, asynchronous active-high reset
//   i_clear      - synchronous flush; overrides any push/pop in the same cycle
//   i_push       - write i_data when a slot is free (or freed by a same-cycle pop)
//   i_data       - entry to write
//   i_pop        - remove the head entry; ignored when empty
//   o_data       - head entry (zero while empty)
//   o_empty      - no entries stored
//   o_full       - DEPTH entries stored
//   o_level      - number of stored entries
module dmt_result_fifo
  import dmt_pkg::*;
#(
  parameter int DATA_WIDTH = 33,
  parameter int DEPTH      = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_clear,
  input  logic                        i_push,
  input  logic [DATA_WIDTH-1:0]       i_data,
  input  logic                        i_pop,
  output logic [DATA_WIDTH-1:0]       o_data,
  output logic                        o_empty,
  output logic                        o_full,
  output logic [ptr_width(DEPTH)-1:0] o_level
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;

  // Status flags and qualified push/pop; a pop in the same cycle frees a slot for a push when full.
  always_comb begin
    w_empty = (r_wr_ptr == r_rd_ptr);
    w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_pop   = i_pop & ~w_empty;
    w_push  = i_push & (~w_full | w_pop);
  end

  // Read and write pointers; clear rewinds both and discards any same-cycle push/pop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
    end else if (i_clear) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1'b1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1'b1);
      end
    end
  end

  // Entry storage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (w_push && !i_clear) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  // Head entry is presented directly (no bypass); it reads as zero while empty.
  always_comb begin
    if (w_empty) begin
      o_data = {DATA_WIDTH{1'b0}};
    end else begin
      o_data = r_mem[r_rd_ptr[AW-1:0]];
    end
  end

  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_level = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/dmt_event_capture.sv
// Event capture front end: synchronises the start/stop event lines, measures the
// ACLK-cycle distance from a start edge to the following stop edge, and queues
// each {sat, count} result in a FWFT FIFO read through the res_if pop port.
// Ports:
//   ACLK, ARESET  - clock, asynchronous active-high reset
//   enable_i      - measurement enable; dropping it aborts a measurement
//   clear_i       - synchronous flush of FSM, counter, FIFO and overflow flag
//   evt_start_i   - asynchronous start event line
//   evt_stop_i    - asynchronous stop event line
//   res_if        - result pop port (data, sat, valid out; ready in)
//   fifo_level_o  - number of stored results
//   busy_o        - measurement in progress
//   overflow_o    - sticky: a result was dropped because the FIFO was full
module dmt_event_capture
  import dmt_pkg::*;
#(
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                             ACLK,
  input  logic                             ARESET,
  input  logic                             enable_i,
  input  logic                             clear_i,
  input  logic                             evt_start_i,
  input  logic                             evt_stop_i,
  dmt_event_capture_if.master              res_if,
  output logic [ptr_width(FIFO_DEPTH)-1:0] fifo_level_o,
  output logic                             busy_o,
  output logic                             overflow_o
);

  localparam int RW = res_width(CNT_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [1:0]           w_evt_raw;
  logic [1:0]           w_evt_pulse;
  logic                 w_start_p;
  logic                 w_stop_p;
  state_t               r_state;
  state_t               w_state_next;
  logic                 w_push;
  logic                 w_cnt_clr;
  logic                 w_cnt_run;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_sat;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic                 w_sat_next;
  logic [RW-1:0]        w_push_data;
  logic [RW-1:0]        w_head;
  logic                 w_empty;
  logic                 w_full;
  logic                 r_overflow;

  assign w_evt_raw = {evt_stop_i, evt_start_i};

  // Index 0 = start, index 1 = stop. Both lines share the same structure, so the
  // start-to-stop latency difference is zero and the measured gap is preserved.
  for (genvar g = 0; g < 2; g++) begin : g_evt
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_last;
    logic                   r_pulse;

    // Synchroniser chain followed by a registered rising-edge detector.
    always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
        r_sync  <= {SYNC_STAGES{1'b0}};
        r_last  <= 1'b0;
        r_pulse <= 1'b0;
      end else begin
        r_sync  <= {r_sync[SYNC_STAGES-2:0], w_evt_raw[g]};
        r_last  <= r_sync[SYNC_STAGES-1];
        r_pulse <= r_sync[SYNC_STAGES-1] & ~r_last;
      end
    end

    assign w_evt_pulse[g] = r_pulse;
  end

  assign w_start_p = w_evt_pulse[0];
  assign w_stop_p  = w_evt_pulse[1];

  // Saturating increment; the pushed value is the post-increment count, so a
  // stop pulse one cycle after the start pulse yields 1.
  always_comb begin
    if (r_cnt == CNT_MAX) begin
      w_cnt_next = r_cnt;
    end else begin
      w_cnt_next = r_cnt + CNT_WIDTH'(1'b1);
    end
    w_sat_next  = r_sat | (w_cnt_next == CNT_MAX);
    w_push_data = {w_sat_next, w_cnt_next};
  end

  // FSM state register; clear forces IDLE.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= ST_IDLE;
    end else if (clear_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and controls. In MEASURE an enable drop wins over a stop
  // pulse, and any start pulse is ignored (no re-arm).
  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_run    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_p && enable_i) begin
          w_state_next = ST_MEASURE;
          w_cnt_clr    = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_MEASURE: begin
        if (!enable_i) begin
          w_state_next = ST_IDLE;
        end else if (w_stop_p) begin
          w_state_next = ST_IDLE;
          w_push       = 1'b1;
        end else begin
          w_state_next = ST_MEASURE;
          w_cnt_run    = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Cycle counter and latched saturation flag.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_cnt <= {CNT_WIDTH{1'b0}};
      r_sat <= 1'b0;
    end else if (clear_i || w_cnt_clr) begin
      r_cnt <= {CNT_WIDTH{1'b0}};
      r_sat <= 1'b0;
    end else if (w_cnt_run) begin
      r_cnt <= w_cnt_next;
      r_sat <= w_sat_next;
    end
  end

  // Sticky overflow: a push found the FIFO full and no pop freed a slot.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_overflow <= 1'b0;
    end else if (clear_i) begin
      r_overflow <= 1'b0;
    end else if (w_push && w_full && !(res_if.res_ready_i && !w_empty)) begin
      r_overflow <= 1'b1;
    end
  end

  dmt_result_fifo #(
    .DATA_WIDTH (RW),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (ACLK),
    .i_rst   (ARESET),
    .i_clear (clear_i),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (res_if.res_ready_i),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_level (fifo_level_o)
  );

  assign res_if.res_data_o  = w_head[CNT_WIDTH-1:0];
  assign res_if.res_sat_o   = w_head[CNT_WIDTH];
  assign res_if.res_valid_o = ~w_empty;
  assign busy_o             = (r_state == ST_MEASURE);
  assign overflow_o         = r_overflow;

endmodule

// File: doc/dmt_event_capture.md
Name: dmt_event_capture

Overview:
- Front-end measurement stage of the difference measurement timer.
- Synchronises two asynchronous event lines (start, stop) and measures the ACLK-cycle distance between a start edge and the following stop edge.
- Queues each result in a small FWFT FIFO.
- The AXI4-Lite register slave consumes the FIFO through a valid/ready pop port; its read of the result register asserts res_ready_i.

Parameters:
- CNT_WIDTH, 32, width of the cycle counter and result word.
- FIFO_DEPTH, 8, number of result entries; power of two, 2..64.
- SYNC_STAGES, 2, synchroniser flops per event input; 2..4.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  asynchronous, active-high reset.
- enable_i  in  1  measurement enable (ACLK domain).
- clear_i  in  1  synchronous flush pulse (ACLK domain).
- evt_start_i  in  1  asynchronous start event line.
- evt_stop_i  in  1  asynchronous stop event line.
- res_data_o  out  CNT_WIDTH  head-of-FIFO result, in cycles.
- res_sat_o  out  1  head entry saturated flag.
- res_valid_o  out  1  FIFO not empty.
- res_ready_i  in  1  pop request; pop occurs when valid & ready.
- fifo_level_o  out  clog2(FIFO_DEPTH)+1  number of stored entries.
- busy_o  out  1  FSM in MEASURE.
- overflow_o  out  1  sticky: a result was dropped because the FIFO was full.

Behaviour:
- Reset: all outputs 0, FSM IDLE, FIFO empty, counter 0, synchronisers 0.
- Input path: SYNC_STAGES flops, then a registered rising-edge detector. Each input produces a one-cycle pulse (start_p, stop_p) SYNC_STAGES+1 cycles after the edge. Both paths have identical latency, so the difference is preserved.
- FSM IDLE:
  - start_p & enable_i: counter <= 0, go to MEASURE.
  - stop_p is ignored.
- FSM MEASURE:
  - Counter increments every cycle and saturates at 2^CNT_WIDTH-1; the sat flag is latched when saturation is reached.
  - On stop_p: push {sat, Tp-Ts}, where Ts and Tp are the start_p and stop_p cycles, then go to IDLE.
  - Start and stop pulses one cycle apart yield result 1.
- Simultaneous events:
  - start_p & stop_p in IDLE: start wins, stop dropped.
  - Both in MEASURE: stop completes the measurement and start is ignored (no re-arm).
  - start_p in MEASURE without stop_p: ignored.
- enable_i low in MEASURE: abort to IDLE next cycle, no push. Results already in the FIFO remain.
- clear_i: highest priority. Next cycle: FSM IDLE, FIFO empty, overflow_o 0, counter 0. Any pop or push in the same cycle is discarded.
- FIFO:
  - First-word-fall-through; res_valid_o rises the cycle after the push.
  - Push while full: result dropped, overflow_o set, contents unchanged.
  - Push and pop in the same cycle when full: pop frees the slot, so the push succeeds and no overflow occurs.
  - Push and pop when empty: no bypass; valid rises next cycle.
  - fifo_level_o updates in the cycle after the push/pop.
- Pointer wrap: log2(FIFO_DEPTH)+1-bit pointers; full/empty are decided by the MSB comparison.
- ARESET mid-measurement: immediate return to the reset state; the partial result is lost.

Decomposition:
- Package dmt_pkg:
  - FSM state encoding (ST_IDLE, ST_MEASURE).
  - Result entry layout (sat bit plus CNT_WIDTH count).
  - FIFO pointer width function.
- Sub-module dmt_result_fifo: synchronous FWFT FIFO, data width CNT_WIDTH+1, with push/pop/level/full/empty. It is reused by the register slave's debug path.
- Synchroniser and edge detect are inline generate loops; they are not a separate module.

Test Plan:
- Basic: enable=1; start rising edge; stop rising edge 100 cycles later -> after 3+1 cycles res_valid_o=1, res_data_o=100, res_sat_o=0, fifo_level_o=1; a pop returns level 0.
- Ordering: start/stop pairs with gaps 5, 17 and 1 -> FIFO yields 5, 17, 1 in order; busy_o toggles per pair; stop pulses without a prior start produce no entry.
- Overflow: FIFO_DEPTH=8, 9 measurements with no pop -> level 8 and overflow_o=1; entries 1..8 are intact. Then pop + push in the same cycle while full -> level stays 8 and the new result is stored at the tail.
- Saturation: CNT_WIDTH=8, gap 300 -> res_data_o=0xFF, res_sat_o=1.
- Control: abort by dropping enable_i 10 cycles after start -> no entry, busy_o=0. Simultaneous start/stop in IDLE -> a measurement begins. clear_i with 3 entries and overflow set -> level 0 and overflow_o=0 next cycle.
- Reset: ARESET asserted asynchronously mid-MEASURE with 2 entries queued -> all outputs 0 immediately. After release, a fresh 42-cycle measurement reads 42.
